// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game_timer block: FSM states, the default
// blank display code and the preset clamp used when a countdown is loaded.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [15:0] BLANK_DEFAULT = 16'hAAAA;

    // Out-of-range fields saturate to their maximum. A bad tens digit means the
    // whole field is over range, so the units digit saturates along with it.
    function automatic logic [15:0] clamp_preset(input logic [15:0] p,
                                                 input logic [7:0]  max_bcd);
        logic [3:0] m10, m1, s10, s1;
        m10 = p[15:12];
        m1  = p[11:8];
        s10 = p[7:4];
        s1  = p[3:0];
        if (s10 > 4'd5) begin
            s10 = 4'd5;
            s1  = 4'd9;
        end else if (s1 > 4'd9) begin
            s1 = 4'd9;
        end
        if (m10 > 4'd9) begin
            {m10, m1} = max_bcd;
        end else begin
            if (m1 > 4'd9) m1 = 4'd9;
            if ({m10, m1} > max_bcd) {m10, m1} = max_bcd;
        end
        return {m10, m1, s10, s1};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counter: synchronous load, up/down count with a programmable
// wrap limit, and a combinational carry/borrow out for chaining.
module bcd_digit
    import game_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       down,
    input  logic       load,
    input  logic [3:0] limit,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       co
);

    logic [3:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = load_val;
        end else if (en) begin
            if (down) val_d = (val_q == 4'd0) ? limit : val_q - 4'd1;
            else      val_d = (val_q == limit) ? 4'd0 : val_q + 4'd1;
        end
    end

    // Carry on up-wrap, borrow on down-wrap; suppressed while loading.
    assign co = en && !load && (down ? (val_q == 4'd0) : (val_q == limit));
    assign q  = val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) val_q <= 4'd0;
        else        val_q <= val_d;
    end

endmodule

// File: rtl/game_timer.sv
// MM:SS game timer with up/down modes, pause, saturation at MAX_MIN:59 and a
// registered BCD display output.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int          CLK_HZ  = 100000000,
    parameter int          MAX_MIN = 99,
    parameter logic [15:0] BLANK   = BLANK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        mode_down,
    input  logic [15:0] preset,
    output logic [15:0] nums,
    output logic        running,
    output logic        tick,
    output logic        expired,
    output logic        saturated
);

    localparam int                PSC_W    = $clog2(CLK_HZ);
    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(CLK_HZ - 1);
    localparam logic [7:0]        MAX_BCD  = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    state_e            state_q, state_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic              mode_q, mode_d;
    logic              sat_q, sat_d;
    logic              tick_q, tick_d;
    logic              exp_q, exp_d;
    logic [15:0]       nums_q, nums_d;
    logic [1:0]        sync_q, sync_d;

    logic              rdy, start_i, pause_i, stop_i;
    logic              ld, cnt_en;
    logic [15:0]       ld_val;
    logic [3:0]        sec1, sec10, min1, min10;
    logic              co_s1, co_s10, co_m1, carry_unused;
    logic [15:0]       digits;
    logic              at_zero, at_one, at_max;

    // Reset release is resynchronised; commands are ignored until it settles.
    assign sync_d  = {sync_q[0], 1'b1};
    assign rdy     = sync_q[1];
    assign start_i = start & rdy;
    assign pause_i = pause & rdy;
    assign stop_i  = stop & rdy;

    assign digits  = {min10, min1, sec10, sec1};
    assign at_zero = (digits == 16'h0000);
    assign at_one  = (digits == 16'h0001);
    assign at_max  = ({min10, min1} == MAX_BCD) && ({sec10, sec1} == 8'h59);

    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        mode_d  = mode_q;
        sat_d   = sat_q;
        tick_d  = 1'b0;
        exp_d   = 1'b0;
        ld      = 1'b0;
        ld_val  = 16'h0000;
        cnt_en  = 1'b0;
        nums_d  = (state_q == IDLE) ? BLANK : digits;

        if (stop_i) begin
            state_d = IDLE;
            psc_d   = '0;
            sat_d   = 1'b0;
            ld      = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d = RUN;
                        psc_d   = '0;
                        mode_d  = mode_down;
                        sat_d   = 1'b0;
                        ld      = 1'b1;
                        ld_val  = mode_down ? clamp_preset(preset, MAX_BCD) : 16'h0000;
                    end
                end
                RUN: begin
                    if (mode_q && at_zero) begin
                        // Only reachable with a 00:00 preset: finish after one RUN cycle.
                        state_d = DONE;
                        psc_d   = '0;
                        exp_d   = 1'b1;
                    end else if (pause_i) begin
                        state_d = PAUSED;
                    end else if (psc_q == PSC_LAST) begin
                        psc_d  = '0;
                        tick_d = 1'b1;
                        if (mode_q) begin
                            cnt_en = 1'b1;
                            if (at_one) begin
                                state_d = DONE;
                                exp_d   = 1'b1;
                            end
                        end else if (at_max) begin
                            sat_d = 1'b1;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end else begin
                        psc_d = psc_q + PSC_W'(1);
                    end
                end
                PAUSED: begin
                    if (pause_i) state_d = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            psc_q   <= '0;
            mode_q  <= 1'b0;
            sat_q   <= 1'b0;
            tick_q  <= 1'b0;
            exp_q   <= 1'b0;
            nums_q  <= BLANK;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            psc_q   <= psc_d;
            mode_q  <= mode_d;
            sat_q   <= sat_d;
            tick_q  <= tick_d;
            exp_q   <= exp_d;
            nums_q  <= nums_d;
        end
    end

    bcd_digit u_sec1 (
        .clk(clk), .rst_n(rst_n), .en(cnt_en), .down(mode_q), .load(ld),
        .limit(4'd9), .load_val(ld_val[3:0]), .q(sec1), .co(co_s1)
    );
    bcd_digit u_sec10 (
        .clk(clk), .rst_n(rst_n), .en(co_s1), .down(mode_q), .load(ld),
        .limit(4'd5), .load_val(ld_val[7:4]), .q(sec10), .co(co_s10)
    );
    bcd_digit u_min1 (
        .clk(clk), .rst_n(rst_n), .en(co_s10), .down(mode_q), .load(ld),
        .limit(4'd9), .load_val(ld_val[11:8]), .q(min1), .co(co_m1)
    );
    bcd_digit u_min10 (
        .clk(clk), .rst_n(rst_n), .en(co_m1), .down(mode_q), .load(ld),
        .limit(4'd9), .load_val(ld_val[15:12]), .q(min10), .co(carry_unused)
    );

    assign nums      = nums_q;
    assign running   = (state_q == RUN);
    assign tick      = tick_q;
    assign expired   = exp_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: two instances (MAX_MIN 99 and 1) share stimulus and are
// compared every cycle against a seconds-based reference model.
module tb_game_timer;

    localparam int HZ     = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAU  = 2;
    localparam int S_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, mode_down = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic [15:0] nums_a, nums_b;
    logic        run_a, run_b, tick_a, tick_b, exp_a, exp_b, sat_a, sat_b;
    int          total = 0;
    int          bad = 0;
    bit          chk_on = 1'b0;

    game_timer #(.CLK_HZ(HZ), .MAX_MIN(99), .BLANK(16'hAAAA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .mode_down(mode_down), .preset(preset), .nums(nums_a), .running(run_a),
        .tick(tick_a), .expired(exp_a), .saturated(sat_a)
    );

    game_timer #(.CLK_HZ(HZ), .MAX_MIN(1), .BLANK(16'hAAAA)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .mode_down(mode_down), .preset(preset), .nums(nums_b), .running(run_b),
        .tick(tick_b), .expired(exp_b), .saturated(sat_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          st;
        int          ph;
        int          secs;
        bit          down;
        bit          sat;
        bit          tick;
        bit          exp;
        logic [15:0] nums;
        int          ec;
    } mdl_t;

    mdl_t ma, mb;

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int preset_secs(input logic [15:0] p, input int maxm);
        int m10, m1, s10, s1, mins, secs;
        m10 = int'(p[15:12]);
        m1  = int'(p[11:8]);
        s10 = int'(p[7:4]);
        s1  = int'(p[3:0]);
        if (s10 > 5) secs = 59;
        else         secs = s10 * 10 + ((s1 > 9) ? 9 : s1);
        if (m10 > 9) begin
            mins = maxm;
        end else begin
            mins = m10 * 10 + ((m1 > 9) ? 9 : m1);
            if (mins > maxm) mins = maxm;
        end
        return mins * 60 + secs;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = S_IDLE; m.ph = 0; m.secs = 0; m.down = 0; m.sat = 0;
        m.tick = 0; m.exp = 0; m.nums = 16'hAAAA; m.ec = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int maxm, input logic st_in,
                                   input logic ps_in, input logic sp_in, input logic md_in,
                                   input logic [15:0] pre);
        mdl_t n;
        n = m;
        n.nums = (m.st == S_IDLE) ? 16'hAAAA : to_bcd(m.secs);
        n.tick = 0;
        n.exp  = 0;
        if (m.ec < 2) begin
            n.ec = m.ec + 1;
            return n;
        end
        if (sp_in) begin
            n.st = S_IDLE; n.ph = 0; n.secs = 0; n.sat = 0;
        end else if ((m.st == S_IDLE || m.st == S_DONE) && st_in) begin
            n.st = S_RUN; n.ph = 0; n.down = md_in; n.sat = 0;
            n.secs = md_in ? preset_secs(pre, maxm) : 0;
        end else if (m.st == S_RUN) begin
            if (m.down && m.secs == 0) begin
                n.st = S_DONE; n.ph = 0; n.exp = 1;
            end else if (ps_in) begin
                n.st = S_PAU;
            end else if (m.ph == HZ - 1) begin
                n.ph = 0;
                n.tick = 1;
                if (m.down) begin
                    n.secs = m.secs - 1;
                    if (n.secs == 0) begin
                        n.st = S_DONE; n.exp = 1;
                    end
                end else if (m.secs == maxm * 60 + 59) begin
                    n.sat = 1;
                end else begin
                    n.secs = m.secs + 1;
                end
            end else begin
                n.ph = m.ph + 1;
            end
        end else if (m.st == S_PAU && ps_in) begin
            n.st = S_RUN;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, 99, start, pause, stop, mode_down, preset);
            mb <= mstep(mb, 1, start, pause, stop, mode_down, preset);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cycle_a", {12'd0, nums_a, run_a, tick_a, exp_a, sat_a},
                {12'd0, ma.nums, ma.st == S_RUN, ma.tick, ma.exp, ma.sat});
            chk("cycle_b", {12'd0, nums_b, run_b, tick_b, exp_b, sat_b},
                {12'd0, mb.nums, mb.st == S_RUN, mb.tick, mb.exp, mb.sat});
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cnt, at, r;

        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        step(); step();
        chk("reset_nums", {16'd0, nums_a}, 32'h0000AAAA);
        chk("reset_flags", {28'd0, run_a, tick_a, exp_a, sat_a}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // Up-count for 61 seconds.
        mode_down = 1'b0; start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        repeat (245) begin step(); cnt += int'(tick_a); end
        chk("up_nums", {16'd0, nums_a}, 32'h00000101);
        chk("up_ticks", cnt, 32'd61);
        chk("up_running", {31'd0, run_a}, 32'd1);
        stop = 1'b1; step(); stop = 1'b0; step();

        // Saturation of the MAX_MIN=1 instance.
        start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 520; i++) begin
            step();
            if (i > 500) cnt += int'(tick_b);
        end
        chk("sat_nums", {16'd0, nums_b}, 32'h00000159);
        chk("sat_flag", {31'd0, sat_b}, 32'd1);
        chk("sat_ticks", cnt, 32'd5);
        stop = 1'b1; step(); stop = 1'b0; step();
        chk("sat_clear", {31'd0, sat_b}, 32'd0);

        // Countdown from 00:03.
        preset = 16'h0003; mode_down = 1'b1; start = 1'b1; step(); start = 1'b0;
        cnt = 0; at = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (exp_a) begin cnt++; at = i; end
        end
        chk("down_exp_count", cnt, 32'd1);
        chk("down_exp_at", at, 32'd12);
        chk("down_done", {15'd0, run_a, nums_a}, 32'h00000000);

        // Zero preset: one RUN cycle then DONE.
        preset = 16'h0000; start = 1'b1; step(); start = 1'b0;
        chk("zero_run", {31'd0, run_a}, 32'd1);
        step();
        chk("zero_done", {30'd0, run_a, exp_a}, 32'd1);
        stop = 1'b1; step(); stop = 1'b0;

        // Pause at prescaler phase 2.
        mode_down = 1'b0; start = 1'b1; step(); start = 1'b0;
        step(); step();
        pause = 1'b1; step(); pause = 1'b0;
        chk("pause_run", {31'd0, run_a}, 32'd0);
        cnt = 0;
        repeat (10) begin step(); cnt += int'(tick_a); end
        chk("pause_ticks", cnt, 32'd0);
        pause = 1'b1; step(); pause = 1'b0;
        chk("resume_run", {31'd0, run_a}, 32'd1);
        step();
        chk("resume_tick1", {31'd0, tick_a}, 32'd0);
        step();
        chk("resume_tick2", {31'd0, tick_a}, 32'd1);
        stop = 1'b1; step(); stop = 1'b0;

        // Clamp, and stop winning over start.
        preset = 16'hA7F9; mode_down = 1'b1; start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0;
        chk("prio_run", {31'd0, run_a}, 32'd0);
        step();
        chk("prio_blank", {16'd0, nums_a}, 32'h0000AAAA);
        start = 1'b1; step(); start = 1'b0; step();
        chk("clamp_a", {16'd0, nums_a}, 32'h00009959);
        chk("clamp_b", {16'd0, nums_b}, 32'h00000159);
        stop = 1'b1; step(); stop = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            start = (r < 6);
            pause = (r >= 6 && r < 14);
            stop  = (r == 14);
            if (start) begin
                mode_down = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) preset = 16'($urandom);
                else preset = {8'h00, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            end
            step();
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0;

        // Asynchronous reset mid-run, then synchronised release.
        stop = 1'b1; step(); stop = 1'b0;
        mode_down = 1'b0; start = 1'b1; step(); start = 1'b0;
        repeat (6) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_nums", {16'd0, nums_a}, 32'h0000AAAA);
        chk("async_run", {31'd0, run_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1;
        step(); step();
        chk("sync_hold", {31'd0, run_a}, 32'd0);
        step();
        chk("sync_go", {31'd0, run_a}, 32'd1);
        start = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
